tcycle_scheduler: RTL and testbench
===================================

Name: tcycle_scheduler

Overview:
Parametrised successor to the fixed CPU/PPU/MEM/SETTLE duty-cycle generator, which hard-codes a 25-clock count and four states. It time-multiplexes the 100 MHz fabric clock into NUM_SLOTS slots of SLOT_LEN clocks per emulated T-cycle, and emits per-slot tick strobes, T-cycle and M-cycle strobes, and a T-cycle count. It adds behaviour the fixed version lacks:
- run/halt at T-cycle boundaries
- single-step for debug
- per-slot enable mask
- double-speed mode (two ticks per slot)

Parameters:
NUM_SLOTS, 4, number of client slots per T-cycle (2..16)
SLOT_LEN, 8, clocks per slot; must be even and >= 2
TCOUNT_W, 32, width of the T-cycle counter

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
run_in  input  1  level; 1 = free-run T-cycles
step_in  input  1  pulse; while halted, execute exactly one T-cycle
speed2x_in  input  1  double-speed mode request
slot_en_in  input  NUM_SLOTS  per-slot tick enable mask
slot_out  output  $clog2(NUM_SLOTS)  currently active slot index
phase_out  output  $clog2(SLOT_LEN)  clock offset within slot
tick_out  output  NUM_SLOTS  one-clock per-slot tclk strobes
tcycle_strobe_out  output  1  high on the last clock of each T-cycle
mcycle_strobe_out  output  1  high on the last clock of every 4th T-cycle
tcount_out  output  TCOUNT_W  completed T-cycle count, wraps
running_out  output  1  high in RUNNING or STEPPING

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE, slot=0, phase=0, tcount=0, slot_en_q=0, speed2x_q=0. All outputs are 0.
- States:
  - IDLE: counters held at (0,0), no strobes.
  - RUNNING
  - STEPPING
- IDLE transitions, evaluated each clock:
  - run_in=1 -> RUNNING.
  - Else step_in=1 -> STEPPING.
  - run_in beats step_in when both are high.
  - In the transition clock, latch slot_en_q<=slot_en_in and speed2x_q<=speed2x_in.
- RUNNING/STEPPING: phase increments every clock. At phase=SLOT_LEN-1, phase wraps to 0 and slot increments. At the end point (slot=NUM_SLOTS-1, phase=SLOT_LEN-1), both wrap to 0.
- At the end point, next state is chosen as follows:
  - STEPPING -> IDLE, always.
  - RUNNING with run_in=0 -> IDLE.
  - RUNNING with run_in=1 -> stay, re-latching slot_en_q and speed2x_q.
  - A halt request never truncates a T-cycle.
- step_in is ignored outside IDLE. run_in going high during STEPPING takes effect at that step's end point.
- Outputs are decoded combinationally from registered state only; there is no input-to-output path.
  - tick_out[s] = running && slot==s && slot_en_q[s] && (phase==0 || (speed2x_q && phase==SLOT_LEN/2)).
  - tcycle_strobe_out = running && end point.
  - mcycle_strobe_out = tcycle_strobe_out && tcount[1:0]==2'b11, using the pre-increment value.
  - tcount increments on tcycle_strobe_out and wraps modulo 2^TCOUNT_W.
- Latency: run_in high at clock edge k gives tick_out[0] (if enabled) during cycle k+1.
- Mask and speed changes mid-T-cycle take effect at the next boundary only.
- Reset asserted mid-T-cycle aborts immediately to reset values, with no strobe.

Decomposition:
- Shared package sched_pkg contains:
  - sched_state_t enum {IDLE, RUNNING, STEPPING}
  - SLOT_W/PHASE_W localparam helpers
- One sub-module: wrap_counter (parametrised MAX, enable in, terminal-count out, async active-low clear).
  - Instantiated twice, cascaded: phase drives slot.

Test Plan:
- Defaults, slot_en_in=4'b1111, run_in=1 from reset release: tick_out[0..3] at clocks 1, 9, 17, 25; tcycle_strobe_out at clock 32; mcycle_strobe_out at clock 128; tcount_out=4 after 128 clocks.
- Running, drop run_in at clock 10: T-cycle completes; tcycle_strobe_out at clock 32; running_out=0 at clock 33; counters hold (0,0).
- Halted, step_in one-clock pulse three times, spaced 40 clocks: exactly 3 tcycle strobes; tcount_out=3; step_in pulsed during STEPPING is ignored.
- speed2x_in=1, slot_en_in=4'b0101: per T-cycle, tick_out[0] at offsets 0 and 4, tick_out[2] at offsets 16 and 20, slots 1 and 3 silent; toggling speed2x_in at offset 12 changes nothing until the next T-cycle.
- rst_n_in low at clock 13 of a T-cycle: all outputs 0 asynchronously with no strobe; after release with run_in=1, first tick_out[0] one clock later.
- NUM_SLOTS=3, SLOT_LEN=2: 6-clock T-cycle; slot_out sequence 0,0,1,1,2,2; tcount_out wraps correctly with TCOUNT_W=3 after 8 T-cycles.

Source files
------------

// File: rtl/tcycle_scheduler_pkg.sv
// Shared types and sizing helpers for the T-cycle scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        STEPPING
    } sched_state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcycle_scheduler_wrap_counter.sv
// Modulo-MAX counter with enable; tc flags the last count value.
import sched_pkg::*;

module wrap_counter #(
    parameter int MAX = 4,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/tcycle_scheduler.sv
// Slices the fabric clock into NUM_SLOTS x SLOT_LEN T-cycles with
// run/halt, single-step, slot masking and double-speed ticks.
import sched_pkg::*;

module tcycle_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_LEN  = 8,
    parameter int TCOUNT_W  = 32
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        run_in,
    input  logic                        step_in,
    input  logic                        speed2x_in,
    input  logic [NUM_SLOTS-1:0]        slot_en_in,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_out,
    output logic [$clog2(SLOT_LEN)-1:0]  phase_out,
    output logic [NUM_SLOTS-1:0]        tick_out,
    output logic                        tcycle_strobe_out,
    output logic                        mcycle_strobe_out,
    output logic [TCOUNT_W-1:0]         tcount_out,
    output logic                        running_out
);

    localparam int SLOT_W  = cnt_w(NUM_SLOTS);
    localparam int PHASE_W = cnt_w(SLOT_LEN);

    sched_state_t         state;
    sched_state_t         state_nx;
    logic                 running;
    logic                 latch;
    logic                 phase_tc;
    logic                 slot_tc;
    logic                 end_pt;
    logic [SLOT_W-1:0]    slot;
    logic [PHASE_W-1:0]   phase;
    logic [NUM_SLOTS-1:0] slot_en_q;
    logic                 speed2x_q;
    logic [TCOUNT_W-1:0]  tcount;

    assign running = (state != IDLE);
    assign end_pt  = running && phase_tc && slot_tc;

    // Phase is the fast digit; slot advances when phase wraps.
    wrap_counter #(.MAX(SLOT_LEN), .W(PHASE_W)) u_phase (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .en    (running),
        .count (phase),
        .tc    (phase_tc)
    );

    wrap_counter #(.MAX(NUM_SLOTS), .W(SLOT_W)) u_slot (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .en    (running && phase_tc),
        .count (slot),
        .tc    (slot_tc)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        unique case (state)
            IDLE: begin
                if (run_in) begin
                    state_nx = RUNNING;
                    latch    = 1'b1;
                end else if (step_in) begin
                    state_nx = STEPPING;
                    latch    = 1'b1;
                end
            end
            RUNNING: begin
                if (end_pt) begin
                    if (run_in) begin
                        latch = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            STEPPING: begin
                if (end_pt) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Mask and speed are sampled only at T-cycle boundaries.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_en_q <= '0;
            speed2x_q <= 1'b0;
        end else if (latch) begin
            slot_en_q <= slot_en_in;
            speed2x_q <= speed2x_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tcount <= '0;
        end else if (end_pt) begin
            tcount <= tcount + 1'b1;
        end
    end

    always_comb begin
        tick_out = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            tick_out[s] = running && (slot == SLOT_W'(s)) && slot_en_q[s] &&
                ((phase == '0) ||
                 (speed2x_q && (phase == PHASE_W'(SLOT_LEN / 2))));
        end
        tcycle_strobe_out = end_pt;
        mcycle_strobe_out = end_pt && (tcount[1:0] == 2'b11);
        slot_out          = slot;
        phase_out         = phase;
        tcount_out        = tcount;
        running_out       = running;
    end

endmodule

// File: tb/tb_tcycle_scheduler.sv
// Bench for tcycle_scheduler: default and 3x2 instances against an
// offset-based reference model.
module tb_tcycle_scheduler;

    typedef struct {
        int     mode;
        int     t;
        longint tcount;
        int     mask;
        bit     sp;
    } model_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        sp = 1'b0;
    logic [3:0]  mask = '0;

    logic [1:0]  slot_a;
    logic [2:0]  phase_a;
    logic [3:0]  tick_a;
    logic        ts_a;
    logic        ms_a;
    logic [31:0] tc_a;
    logic        run_a;

    logic [1:0]  slot_b;
    logic [0:0]  phase_b;
    logic [2:0]  tick_b;
    logic        ts_b;
    logic        ms_b;
    logic [2:0]  tc_b;
    logic        run_b;

    int     nerr = 0;
    int     nchk = 0;
    int     nts = 0;
    model_t ma;
    model_t mb;
    model_t m0;

    always #5 clk = ~clk;

    tcycle_scheduler dut_a (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .run_in            (run),
        .step_in           (step),
        .speed2x_in        (sp),
        .slot_en_in        (mask),
        .slot_out          (slot_a),
        .phase_out         (phase_a),
        .tick_out          (tick_a),
        .tcycle_strobe_out (ts_a),
        .mcycle_strobe_out (ms_a),
        .tcount_out        (tc_a),
        .running_out       (run_a)
    );

    tcycle_scheduler #(.NUM_SLOTS(3), .SLOT_LEN(2), .TCOUNT_W(3)) dut_b (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .run_in            (run),
        .step_in           (step),
        .speed2x_in        (sp),
        .slot_en_in        (mask[2:0]),
        .slot_out          (slot_b),
        .phase_out         (phase_b),
        .tick_out          (tick_b),
        .tcycle_strobe_out (ts_b),
        .mcycle_strobe_out (ms_b),
        .tcount_out        (tc_b),
        .running_out       (run_b)
    );

    function automatic model_t mstep(model_t m, bit r, bit s, int en,
                                     bit s2, int n, int l, int tw);
        model_t o = m;
        if (m.mode == 0) begin
            if (r) begin
                o.mode = 1; o.mask = en; o.sp = s2;
            end else if (s) begin
                o.mode = 2; o.mask = en; o.sp = s2;
            end
        end else if (m.t == n * l - 1) begin
            o.t = 0;
            o.tcount = (m.tcount + 1) % (longint'(1) << tw);
            if (m.mode == 2 || !r) begin
                o.mode = 0;
            end else begin
                o.mask = en; o.sp = s2;
            end
        end else begin
            o.t = m.t + 1;
        end
        return o;
    endfunction

    function automatic int exp_tick(model_t m, int l);
        int sl = m.t / l;
        int ph = m.t % l;
        if (m.mode != 0 && ((m.mask >> sl) & 1) == 1 &&
            (ph == 0 || (m.sp && ph == l / 2)))
            return 1 << sl;
        return 0;
    endfunction

    function automatic int exp_ts(model_t m, int n, int l);
        return (m.mode != 0 && m.t == n * l - 1) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act,
                       input longint expv);
        nchk++;
        assert (act === 64'(expv)) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    task automatic chk_all();
        chk("a_slot", 64'(slot_a), ma.t / 8);
        chk("a_phase", 64'(phase_a), ma.t % 8);
        chk("a_tick", 64'(tick_a), exp_tick(ma, 8));
        chk("a_tstrobe", 64'(ts_a), exp_ts(ma, 4, 8));
        chk("a_mstrobe", 64'(ms_a),
            (exp_ts(ma, 4, 8) == 1 && ma.tcount % 4 == 3) ? 1 : 0);
        chk("a_tcount", 64'(tc_a), ma.tcount);
        chk("a_running", 64'(run_a), (ma.mode != 0) ? 1 : 0);
        chk("b_slot", 64'(slot_b), mb.t / 2);
        chk("b_phase", 64'(phase_b), mb.t % 2);
        chk("b_tick", 64'(tick_b), exp_tick(mb, 2));
        chk("b_tstrobe", 64'(ts_b), exp_ts(mb, 3, 2));
        chk("b_mstrobe", 64'(ms_b),
            (exp_ts(mb, 3, 2) == 1 && mb.tcount % 4 == 3) ? 1 : 0);
        chk("b_tcount", 64'(tc_b), mb.tcount);
        chk("b_running", 64'(run_b), (mb.mode != 0) ? 1 : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            ma = mstep(ma, run, step, int'(mask), sp, 4, 8, 32);
            mb = mstep(mb, run, step, int'(mask & 4'b0111), sp, 3, 2, 3);
        end
        @(negedge clk);
        if (ts_a) nts++;
        chk_all();
    endtask

    initial begin
        int     base_ts;
        longint base_tc;
        int     guard;
        m0 = '{mode: 0, t: 0, tcount: 0, mask: 0, sp: 1'b0};
        ma = m0;
        mb = m0;

        repeat (2) @(negedge clk);
        chk_all();

        // free run from reset release, all slots enabled
        run = 1'b1;
        mask = 4'b1111;
        rst_n = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            cyc();
            if (i == 1)   chk("first_tick", 64'(tick_a), 1);
            if (i == 9)   chk("tick_slot1", 64'(tick_a), 2);
            if (i == 25)  chk("tick_slot3", 64'(tick_a), 8);
            if (i == 32)  chk("tstrobe_32", 64'(ts_a), 1);
            if (i == 128) chk("mstrobe_128", 64'(ms_a), 1);
            if (i == 129) chk("tcount_4", 64'(tc_a), 4);
        end

        // halt request mid T-cycle completes the cycle
        guard = 0;
        while (ma.t != 9 && guard < 64) begin
            cyc();
            guard++;
        end
        chk("reach_off9", 64'(ma.t), 9);
        run = 1'b0;
        repeat (30) cyc();
        chk("halted", 64'(run_a), 0);
        chk("hold_slot", 64'(slot_a), 0);

        // three single steps, with an ignored step mid-step
        base_ts = nts;
        base_tc = ma.tcount;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            repeat (5) cyc();
            step = 1'b1;
            cyc();
            step = 1'b0;
            repeat (33) cyc();
        end
        chk("step_strobes", 64'(nts - base_ts), 3);
        chk("step_tcount", 64'(tc_a), base_tc + 3);

        // double speed, sparse mask, speed toggled mid T-cycle
        sp = 1'b1;
        mask = 4'b0101;
        run = 1'b1;
        cyc();
        chk("sp_tick0", 64'(tick_a), 1);
        repeat (4) cyc();
        chk("sp_tick0_half", 64'(tick_a), 1);
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (ma.t == 11) sp = ~sp;
        end

        // randomized operation
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            step = ($urandom_range(0, 9) == 0);
            sp = $urandom_range(0, 1);
            mask = 4'($urandom);
            cyc();
        end
        step = 1'b0;

        // asynchronous reset in the middle of a T-cycle
        run = 1'b1;
        mask = 4'b1111;
        guard = 0;
        while (!(ma.mode == 1 && ma.t == 12) && guard < 200) begin
            cyc();
            guard++;
        end
        chk("reach_off12", 64'(ma.t), 12);
        #2 rst_n = 1'b0;
        #1;
        ma = m0;
        mb = m0;
        chk("rst_running", 64'(run_a), 0);
        chk("rst_tstrobe", 64'(ts_a), 0);
        chk("rst_tcount", 64'(tc_a), 0);
        chk_all();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_first_tick", 64'(tick_a), 1);
        repeat (40) cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
